// File: rtl/request_encoder.sv
// Registered priority encoder: collects multi-hot request strobes into a pending store
// and hands out one binary index per valid/ready handshake, lowest index first.
module request_encoder #(
  parameter int N  = 32,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_in,
  input  logic          clear,
  input  logic          ready_in,
  output logic          valid_out,
  output logic [IW-1:0] idx_out,
  output logic [N-1:0]  pending_out,
  output logic [IW:0]   count_out,
  output logic          busy
);

  logic [N-1:0]  r_pending;
  logic          r_valid;
  logic [IW-1:0] r_idx;
  logic [IW:0]   r_count;

  logic          w_slotFree;
  logic          w_hasSel;
  logic          w_load;
  logic [IW-1:0] w_sel;
  logic [N-1:0]  w_served;
  logic [N-1:0]  w_nextPending;
  logic [IW:0]   w_nextCount;

  assign w_slotFree = !r_valid || ready_in;
  assign w_hasSel   = |r_pending;
  assign w_load     = w_slotFree && w_hasSel;

  // Scan from the top down so the lowest set index is the one left standing.
  always_comb begin
    w_sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_pending[i]) w_sel = IW'(i);
    end
  end

  always_comb begin
    w_served = '0;
    for (int i = 0; i < N; i++) begin
      w_served[i] = w_load && (w_sel == IW'(i));
    end
  end

  // A fresh strobe on the bit being served re-arms it rather than being lost.
  assign w_nextPending = (r_pending & ~w_served) | req_in;

  always_comb begin
    w_nextCount = '0;
    for (int i = 0; i < N; i++) begin
      w_nextCount = w_nextCount + (IW+1)'(w_nextPending[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_count   <= '0;
    end else if (clear) begin
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_count   <= '0;
    end else begin
      r_pending <= w_nextPending;
      r_count   <= w_nextCount;
      if (w_load) begin
        r_valid <= 1'b1;
        r_idx   <= w_sel;
      end else if (w_slotFree) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign valid_out   = r_valid;
  assign idx_out     = r_idx;
  assign pending_out = r_pending;
  assign count_out   = r_count;
  assign busy        = (|r_pending) || r_valid;

endmodule

// File: doc/request_encoder.md
# request_encoder

Registered 32-to-5 priority encoder with a pending-request store and a valid/ready output handshake; it is the inverse of the thirty-two-way one-hot decoder and turns multi-hot request strobes back into binary indices, one per handshake. Sits between per-line request sources (interrupt or trap lines, per-register write flags) and a single consumer that accepts one encoded index at a time. Lowest index has highest priority, matching the decoder's F[0] for S=0 ordering.

## Interface

- N, 32, number of request lines; legal values 2..32.
- IW, 5, index width; must equal ceil(log2(N)).

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_in  input  N  request strobes; each asserted bit sets its pending bit at the next clk edge
- clear  input  1  synchronous flush of pending store and output slot
- ready_in  input  1  consumer accepts idx_out this cycle
- valid_out  output  1  idx_out holds a valid encoded request
- idx_out  output  IW  binary index of the served request
- pending_out  output  N  current pending store, not including the bit held in the output slot
- count_out  output  IW+1  number of set bits in pending_out
- busy  output  1  (|pending_out) | valid_out, combinational from registers

## Operation

- State: pending[N-1:0] register; output slot {valid_out, idx_out} register; count_out register.
- Reset (rst=1, asynchronous): pending=0, valid_out=0, idx_out=0, count_out=0; busy=0.
- Slot free this cycle: slot_free = !valid_out | ready_in.
- Pick: sel = lowest-index set bit of pending (the registered value, not req_in); has_sel = |pending.
- At each clk edge, with clear=0:
  - Slot load: if slot_free & has_sel, then valid_out<=1, idx_out<=sel. Else if slot_free, valid_out<=0 and idx_out holds.
  - Pending update: pending <= (pending & ~served) | req_in, where served = one-hot(sel) if a load occurs, else 0. Set has priority over clear: a req_in bit equal to the served bit stays pending and is served again later.
  - count_out <= popcount of the new pending value.
- With clear=1 at an edge: pending<=0, valid_out<=0, count_out<=0, idx_out holds; req_in on that edge is dropped; a handshake in the same cycle completes (the consumer has taken it), and nothing new loads.
- Repeated req_in on an already-pending bit merges; no duplicate service.
- Bits above N-1 do not exist; idx_out never exceeds N-1.
- idx_out stable while valid_out=1 and ready_in=0.

## Timing

- Request latency: req_in bit set during cycle k -> pending bit visible after edge k -> valid_out/idx_out after edge k+1 (2 cycles) if the slot is free.
- Throughput: one index per cycle with ready_in held high and pending non-empty.
- Handshake: transfer occurs on an edge where valid_out=1 and ready_in=1. valid_out must not drop without a transfer, except on clear or rst.
- ready_in may be asserted with valid_out=0; it has no effect.
- pending_out, count_out, and busy change only on clk edges or rst; there is no combinational path from any input to any output.
- rst mid-transfer: all state is lost immediately; the consumer sees valid_out=0 asynchronously.

## Test plan

- Reset: assert rst mid-stream with pending=0xFFFF_FFFF -> valid_out=0, idx_out=0, pending_out=0, count_out=0, busy=0 without a clock edge.
- Priority drain: single-cycle req_in=0x8000_0011, ready_in=1 -> idx_out sequence 0, 4, 31 on consecutive cycles starting 2 cycles later, then valid_out=0 and busy=0; count_out sequence 3, 2, 1, 0.
- Back-pressure: req_in=0x0000_0006, ready_in=0 for 5 cycles -> valid_out=1 with idx_out=1 held stable, pending_out=0x4, count_out=1; release ready -> 1 then 2.
- Re-request of served bit: pending=0x1 and req_in=0x1 on the load edge -> idx_out=0 twice across two handshakes, then empty.
- Clear: pending=0x0F0, valid_out=1, and clear=1 with req_in=0x100 on the same edge -> pending_out=0, valid_out=0, count_out=0; bit 8 is never served.
- Parameter N=8, IW=3: req_in=0x80 -> idx_out=7; random multi-hot stimulus against a reference model checks ascending service order and no lost or duplicated requests.
